// File: rtl/fetch_unit.sv
// fetch_unit -- fetch stage.
//
// Holds the PC and issues one read at a time to a multi-cycle instruction
// memory. Each returned word is held with its PC+2 until decode takes it. A
// redirect from execute discards wrong-path work. Fetching stops after a HALT
// word (opcode bits [15:11] == 0) is consumed.
//
// Memory handshake: imem_rd is a one-cycle request for the word at imem_addr.
// It is raised only in FETCH and only while imem_stall is low. imem_done marks
// imem_data as valid. It may arrive in the same cycle as imem_rd (a hit) or in
// any later cycle. Only one request is ever outstanding. A done that arrives
// with no request outstanding is ignored.
//
// Decode handshake: inst_valid=1 presents Inst/PCinc. The word is consumed on a
// cycle where stall=0. While stall=1, Inst, PCinc and PC all hold.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   newPC        redirect target (bit 0 ignored)
//   redirect     newPC valid this cycle; highest priority
//   stall        decode cannot accept the held instruction
//   imem_addr    memory address (= PC)
//   imem_rd      memory read request
//   imem_stall   memory busy, no request issued
//   imem_done    imem_data valid this cycle
//   imem_data    instruction word from memory
//   Inst         held instruction, NOP_INST when not valid
//   PCinc        PC of held instruction + 2
//   inst_valid   Inst/PCinc valid for decode
//   halted       HALT consumed, fetching stopped
//   fsm_state    current state (debug): 0 FETCH, 1 WAIT, 2 VALID, 3 HALTED
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] newPC,
  input  logic        redirect,
  input  logic        stall,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic [15:0] Inst,
  output logic [15:0] PCinc,
  output logic        inst_valid,
  output logic        halted,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_VALID  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pcinc_q, pcinc_d;
  logic        squash_q, squash_d;

  logic [15:0] pc_plus2;
  logic        hit;
  logic        is_halt;
  logic        unused_newpc_lsb;

  assign unused_newpc_lsb = newPC[0];

  // Wraps naturally at 16 bits: 16'hFFFE + 2 = 16'h0000.
  assign pc_plus2 = pc_q + 16'd2;
  assign imem_rd  = (state_q == S_FETCH) && !imem_stall;
  assign hit      = imem_rd && imem_done;
  assign is_halt  = (inst_q[15:11] == 5'b00000);

  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_VALID);
  assign halted     = (state_q == S_HALTED);
  assign Inst       = inst_valid ? inst_q : NOP_INST;
  assign PCinc      = pcinc_q;
  assign fsm_state  = state_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pcinc_d  = pcinc_q;
    squash_d = squash_q;

    if (redirect) begin
      pc_d = {newPC[15:1], 1'b0};
      case (state_q)
        S_FETCH: begin
          // A read issued in this cycle cannot be cancelled. Wait for it and
          // drop its data. A same-cycle hit is simply dropped.
          if (imem_rd && !imem_done) begin
            squash_d = 1'b1;
            state_d  = S_WAIT;
          end else begin
            state_d  = S_FETCH;
          end
        end
        S_WAIT: begin
          // If the outstanding read returns in the redirect cycle, nothing is
          // left in flight, so restart straight away.
          if (imem_done) begin
            squash_d = 1'b0;
            state_d  = S_FETCH;
          end else begin
            squash_d = 1'b1;
            state_d  = S_WAIT;
          end
        end
        default: begin
          // VALID drops the held word; HALTED resumes fetching.
          state_d = S_FETCH;
        end
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (hit) begin
            inst_d  = imem_data;
            pcinc_d = pc_plus2;
            state_d = S_VALID;
          end else if (imem_rd) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_done) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = S_FETCH;
            end else begin
              inst_d  = imem_data;
              pcinc_d = pc_plus2;
              state_d = S_VALID;
            end
          end
        end
        S_VALID: begin
          if (!stall) begin
            pc_d    = pc_plus2;
            state_d = is_halt ? S_HALTED : S_FETCH;
          end
        end
        S_HALTED: begin
          state_d = S_HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      pcinc_q  <= 16'h0000;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pcinc_q  <= pcinc_d;
      squash_q <= squash_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] newPC = '0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_stall = 1'b1;
  logic        imem_done = 1'b0;
  logic [15:0] imem_data = '0;
  logic [15:0] Inst;
  logic [15:0] PCinc;
  logic        inst_valid;
  logic        halted;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst_n(rst_n), .newPC(newPC), .redirect(redirect), .stall(stall),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_stall(imem_stall),
    .imem_done(imem_done), .imem_data(imem_data), .Inst(Inst), .PCinc(PCinc),
    .inst_valid(inst_valid), .halted(halted), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory + reference model ----------------
  logic [15:0] mem [0:255];
  int lat_lo = 0;
  int lat_hi = 0;

  function automatic logic [15:0] mem_at(input logic [15:0] a);
    return mem[a[8:1]];
  endfunction

  // Transaction-level view: the PC decode should see, whether a word is held,
  // whether fetching stopped, and the single outstanding read (if any).
  logic [15:0] m_pc;
  bit          m_hold, m_halted, m_out, m_live;
  int          m_cnt;
  logic [15:0] m_addr;

  task automatic model_reset();
    m_pc = 16'h0000; m_hold = 0; m_halted = 0;
    m_out = 0; m_live = 0; m_cnt = 0; m_addr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, imem_addr, 16'h0000);
    check({tag, "_valid"}, 16'(inst_valid), 16'd0);
    check({tag, "_halted"}, 16'(halted), 16'd0);
    check({tag, "_inst"}, Inst, NOP);
    check({tag, "_pcinc"}, PCinc, 16'h0000);
    check({tag, "_state"}, 16'(fsm_state), 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 0; redirect = 0; newPC = '0;
    imem_stall = 1'b1; imem_done = 0; imem_data = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic s, input logic rdir, input logic [15:0] npc, input logic ist);
    logic        resp;
    logic        exp_rd;
    logic [15:0] w;
    @(negedge clk);
    check("inst_valid", 16'(inst_valid), 16'(m_hold));
    check("halted", 16'(halted), 16'(m_halted));
    check("imem_addr", imem_addr, m_pc);
    if (m_hold) begin
      check("inst", Inst, mem_at(m_pc));
      check("pcinc", PCinc, m_pc + 16'd2);
    end else begin
      check("inst_nop", Inst, NOP);
    end
    stall = s; redirect = rdir; newPC = npc; imem_stall = ist;
    resp = 1'b0;
    imem_done = 1'b0;
    imem_data = 16'($urandom);
    if (m_out && m_cnt == 0) begin
      imem_done = 1'b1;
      imem_data = mem_at(m_addr);
      resp = 1'b1;
    end
    #1;
    exp_rd = !ist && !m_hold && !m_halted && !m_out;
    check("imem_rd", 16'(imem_rd), 16'(exp_rd));
    if (exp_rd) begin
      m_out = 1; m_live = 1; m_addr = m_pc;
      m_cnt = $urandom_range(lat_hi, lat_lo);
      if (m_cnt == 0) begin
        imem_done = 1'b1;
        imem_data = mem_at(m_addr);
        resp = 1'b1;
      end
    end
    @(posedge clk);
    if (m_out && !resp) m_cnt--;
    if (rdir) begin
      m_pc = {npc[15:1], 1'b0};
      m_hold = 0; m_halted = 0;
      if (resp) m_out = 0;
      else if (m_out) m_live = 0;
    end else if (m_hold) begin
      if (!s) begin
        w = mem_at(m_pc);
        m_hold = 0;
        if (w[15:11] == 5'd0) m_halted = 1;
        m_pc = m_pc + 16'd2;
      end
    end else if (resp) begin
      m_out = 0;
      if (m_live) m_hold = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [15:0] r;
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 + 16'(i);

    // 1: hits, three words, stop on HALT.
    mem[0] = 16'h4000; mem[1] = 16'h4001; mem[2] = 16'h0000;
    do_reset();
    #1 check_reset_outputs("reset");
    lat_lo = 0; lat_hi = 0;
    idle(8);
    #1;
    check("t1_halted", 16'(halted), 16'd1);
    check("t1_pc", imem_addr, 16'h0006);
    check("t1_rd", 16'(imem_rd), 16'd0);

    // 2: 3-cycle memory, decode stalls twice on the held word.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    #1;
    check("t2_held", Inst, 16'h4000);
    check("t2_pc", imem_addr, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    #1 check("t2_pc_next", imem_addr, 16'h0002);

    // 3: redirect while the read is outstanding.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    #1 check("t3_addr", imem_addr, 16'h0040);
    idle(6);

    // 4: redirect (odd target) while decode stalls a held word.
    do_reset();
    lat_lo = 0; lat_hi = 0;
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 16'h0011, 1'b0);
    #1;
    check("t4_valid", 16'(inst_valid), 16'd0);
    check("t4_addr", imem_addr, 16'h0010);
    idle(3);

    // 5: PC+2 wrap at the top of memory.
    do_reset();
    mem[255] = 16'h4000;
    step(1'b0, 1'b1, 16'hFFFE, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    #1 check("t5_pcinc", PCinc, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    #1 check("t5_addr", imem_addr, 16'h0000);

    // 6: asynchronous reset during WAIT; a stale done must be ignored.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b1, 16'h0080, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    imem_stall = 1'b1;
    #1 check_reset_outputs("t6_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    imem_done = 1'b1; imem_data = 16'h4321;
    @(posedge clk);
    #1 check("t6_stale", 16'(inst_valid), 16'd0);
    lat_lo = 0; lat_hi = 0;
    idle(4);

    // Random: random program, latencies, stalls and redirects.
    for (int i = 0; i < 256; i++) begin
      r = 16'($urandom);
      if ($urandom_range(7, 0) == 0) r[15:11] = 5'd0;
      mem[i] = r;
    end
    do_reset();
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 4,
           16'($urandom), $urandom_range(99, 0) < 25);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
